mult_seq_unit: RTL

- Iterative shift-and-add multiplier for MULT/MULTU in the MIPS datapath; produces the 64-bit HI/LO product.
- Sits directly upstream of the 32-bit ripple adder. Each cycle it drives the adder's A/B/CarryIn and consumes its sum/carry.
- One partial-product add per clock, 32 iterations, then an optional sign-correction cycle.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/mult_seq_unit_if.sv | 24 ++
 rtl/mult_seq_unit_fadder32.sv | 24 ++
 rtl/mult_seq_unit.sv | 113 +++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions for the sequential multiplier: widths,
// iteration count, FSM state encoding and the operand magnitude helper.
package mips_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned PROD_W    = 2 * DATA_W;
    localparam int unsigned MULT_ITER = 32;
    localparam int unsigned CNT_W     = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    // |x| for a two's-complement word; 0x80000000 maps to itself and is read as unsigned.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? DATA_W'((~x) + DATA_W'(1)) : x;
    endfunction

endpackage

// File: rtl/mult_seq_unit_if.sv
// Request/result bundle between the issue logic (master) and the multiplier (slave).
interface mult_seq_unit_if;
    import mips_pkg::*;

    logic              start;
    logic              is_signed;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, is_signed, op_a, op_b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, op_a, op_b,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mult_seq_unit_fadder32.sv
// 32-bit ripple-carry adder of the MIPS datapath, reused for each partial-product add.
module mult_seq_unit_fadder32
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              carry_in,
    output logic [DATA_W-1:0] sum,
    output logic              carry_out
);

    // Bit-serial carry chain, one full adder per bit.
    always_comb begin
        logic c;
        c   = carry_in;
        sum = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        carry_out = c;
    end

endmodule

// File: rtl/mult_seq_unit.sv
// Iterative shift-and-add MULT/MULTU: 32 add/shift steps through the shared
// ripple adder, then one cycle of optional sign correction into HI/LO.
module mult_seq_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    mult_seq_unit_if.slave   bus
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [PROD_W-1:0]  p_q, p_d;
    logic               neg_q, neg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [DATA_W-1:0]  hi_q, hi_d;
    logic [DATA_W-1:0]  lo_q, lo_d;

    logic [DATA_W-1:0]  add_b_c;
    logic [DATA_W-1:0]  add_sum_c;
    logic               add_cout_c;
    logic [PROD_W-1:0]  result_c;

    assign add_b_c = p_q[0] ? DATA_W'(mcand_q) : '0;

    mult_seq_unit_fadder32 u_fadder32 (
        .a         (p_q[PROD_W-1:DATA_W]),
        .b         (add_b_c),
        .carry_in  (1'b0),
        .sum       (add_sum_c),
        .carry_out (add_cout_c)
    );

    // Sign correction of the unsigned magnitude product.
    assign result_c = neg_q ? PROD_W'((~p_q) + PROD_W'(1)) : p_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            mcand_q <= '0;
            p_q     <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mcand_q <= mcand_d;
            p_q     <= p_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mcand_d = mcand_q;
        p_d     = p_q;
        neg_d   = neg_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CALC;
                    count_d = '0;
                    mcand_d = WIDTH'(bus.is_signed ? magnitude(bus.op_a) : bus.op_a);
                    p_d     = {{DATA_W{1'b0}},
                               (bus.is_signed ? magnitude(bus.op_b) : bus.op_b)};
                    neg_d   = bus.is_signed & (bus.op_a[DATA_W-1] ^ bus.op_b[DATA_W-1]);
                end
            end
            CALC: begin
                // Carry-out lands in P[63] before the right shift, so no bit is lost.
                p_d     = {add_cout_c, add_sum_c, p_q[DATA_W-1:1]};
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(MULT_ITER - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                hi_d    = result_c[PROD_W-1:DATA_W];
                lo_d    = result_c[DATA_W-1:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
